cp0_multi_issue: RTL and testbench
==================================

// Module: cp0_multi_issue
// PURPOSE
//  Parametrised coprocessor-0 for the N-lane superscalar MIPS core, sitting at the MEM/WB boundary.
//  - Holds BadVAddr, Count, Compare, Status, Cause and EPC.
//  - Arbitrates exceptions, interrupts and ERET across issue lanes in program order (lane 0 is oldest).
//  - Drives the pipeline flush and redirect target.
//  - Adds a prescaled timer, a timer interrupt and a per-lane kill mask.
// PARAMETERS
//  LANES      2             issue lanes handled per cycle (1..4)
//  HW_INT     6             external interrupt lines, mapped to Cause.IP[9+HW_INT:10]
//  COUNT_DIV  2             Count increments once every COUNT_DIV clocks (>=1)
//  EXC_VEC    32'hBFC00380  redirect target for exceptions and interrupts
// PORTS
//  clk         in   1          clock, rising edge
//  reset       in   1          synchronous, active-low
//  hw_int      in   HW_INT     level-sensitive external interrupt requests
//  lane_valid  in   LANES      lane holds a real instruction this cycle
//  exc_valid   in   LANES      lane raises an exception
//  exc_code    in   5*LANES    MIPS ExcCode per lane
//  exc_pc      in   32*LANES   PC of the lane's instruction
//  exc_bd      in   LANES      lane's instruction is in a delay slot
//  exc_badva   in   32*LANES   faulting address for AdEL/AdES
//  eret        in   LANES      lane executes ERET
//  wr_en       in   LANES      MTC0 write enable
//  wr_addr     in   5*LANES    MTC0 register number
//  wr_data     in   32*LANES   MTC0 data
//  rd_addr     in   5*LANES    MFC0 register number
//  rd_data     out  32*LANES   MFC0 data, combinational
//  flush       out  1          redirect the pipeline this cycle
//  kill_mask   out  LANES      lanes to squash (the winner and all younger lanes)
//  redirect_pc out  32         EXC_VEC, or EPC on ERET
//  status_exl  out  1          Status.EXL
//  timer_int   out  1          Cause.TI
// BEHAVIOUR
//  Registers and fields
//   - Reset (reset==0 at posedge): Status=32'h0040_0000; all other registers, prescaler and outputs 0.
//   - Writable fields:
//     * Status: IM[15:8], EXL[1], IE[0]
//     * Cause: IP[9:8]
//     * Count, Compare, EPC: full 32 bits
//   - BadVAddr is read-only. Unmapped read addresses return 0.
//  Interrupts and timer
//   - Each cycle, Cause.IP[9+HW_INT:10] <= hw_int.
//   - Cause.IP[15] = TI | hw_int[5]. This bit is ORed when HW_INT=6 and is the timer alone when HW_INT<6.
//   - Count: prescaler counts 0..COUNT_DIV-1, and Count increments when it wraps. Count wraps 32'hFFFF_FFFF -> 0.
//   - An MTC0 to Count loads the written value and clears the prescaler.
//   - TI sets on the cycle Count==Compare while Compare!=0. TI holds until Compare is written, which clears TI.
//   - int_req = Status.IE & ~Status.EXL & |(Cause.IP[15:8] & Status.IM). int_req is registered state only.
//  Arbitration (combinational, same cycle)
//   - Priority: int_req (only if lane_valid[0]) > lowest-index lane with exc_valid or eret.
//   - Winner index w: interrupts use w=0. flush=1 and kill_mask = all lanes with index >= w.
//   - Outputs with no winner: flush=0, kill_mask=0, redirect_pc=EXC_VEC.
//  Commit on the next edge
//   - Exception or interrupt:
//     * If EXL==0: EPC <= exc_bd[w] ? exc_pc[w]-4 : exc_pc[w], and Cause.BD <= exc_bd[w].
//     * If EXL==1: EPC and BD are left unchanged.
//     * Always: EXL <= 1; Cause.ExcCode <= (interrupt ? 0 : exc_code[w]).
//     * BadVAddr <= exc_badva[w] for ExcCode 4/5.
//     * A PC-misaligned fetch supplies the fetch PC as exc_badva.
//   - ERET winner: EXL <= 0; redirect_pc = EPC.
//   - Exception/interrupt updates take priority over MTC0 writes to the same field in the same cycle.
//  MTC0 ordering
//   - A lane's write commits only if the lane is not in kill_mask.
//   - Several surviving writes to one register: the highest-index lane wins.
//  Reads
//   - Reads return pre-edge state. There is no write-to-read bypass, so the core forwards MTC0->MFC0 itself.
//  Reset mid-operation
//   - Reset overrides pending events, flushes nothing and zeroes the prescaler.
// TESTING
//  1. LANES=2; lane1 exc_valid, code 5'd12, pc 32'h8000_0104, bd=0
//     -> flush=1, kill_mask=2'b10; next cycle EPC=32'h8000_0104, ExcCode=12, EXL=1.
//  2. Both lanes except: lane0 code 8, lane1 code 12
//     -> lane0 wins, kill_mask=2'b11, ExcCode=8.
//     Lane0 bd=1, pc 32'h8000_0200 -> EPC=32'h8000_01FC, BD=1.
//  3. Compare=10, COUNT_DIV=2, IE=1, IM[7]=1
//     -> TI rises when Count==10 (cycle ~20 after Count clear).
//     Next cycle an interrupt is taken on lane0 with ExcCode 0.
//     Writing Compare clears TI.
//  4. lane0 MTC0 Status=1, lane1 MTC0 Status=0 in the same cycle, no exceptions -> Status.IE=0 (lane1 wins).
//     Repeat with lane0 raising an exception -> both writes dropped.
//  5. EXL=1, EPC=32'h8000_0040; lane1 eret
//     -> redirect_pc=32'h8000_0040, kill_mask=2'b10, EXL=0 next cycle.
//     An exception raised while EXL=1 keeps EPC unchanged.
//  6. Assert reset while TI=1 and EXL=1
//     -> next cycle Status=32'h0040_0000, Cause=0, flush=0.

Source files
------------

// File: rtl/cp0_multi_issue.sv
// Coprocessor 0 for the N-lane superscalar core: CP0 register file, prescaled Count/Compare
// timer, and in-order exception / interrupt / ERET arbitration across the issue lanes.
module cp0_multi_issue #(
    parameter int unsigned LANES     = 2,
    parameter int unsigned HW_INT    = 6,
    parameter int unsigned COUNT_DIV = 2,
    parameter logic [31:0] EXC_VEC   = 32'hBFC0_0380
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [HW_INT-1:0]     hw_int,
    input  logic [LANES-1:0]      lane_valid,
    input  logic [LANES-1:0]      exc_valid,
    input  logic [5*LANES-1:0]    exc_code,
    input  logic [32*LANES-1:0]   exc_pc,
    input  logic [LANES-1:0]      exc_bd,
    input  logic [32*LANES-1:0]   exc_badva,
    input  logic [LANES-1:0]      eret,
    input  logic [LANES-1:0]      wr_en,
    input  logic [5*LANES-1:0]    wr_addr,
    input  logic [32*LANES-1:0]   wr_data,
    input  logic [5*LANES-1:0]    rd_addr,
    output logic [32*LANES-1:0]   rd_data,
    output logic                  flush,
    output logic [LANES-1:0]      kill_mask,
    output logic [31:0]           redirect_pc,
    output logic                  status_exl,
    output logic                  timer_int
);

    localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(COUNT_DIV - 1);

    localparam logic [4:0] A_BADVA   = 5'd8;
    localparam logic [4:0] A_COUNT   = 5'd9;
    localparam logic [4:0] A_COMPARE = 5'd11;
    localparam logic [4:0] A_STATUS  = 5'd12;
    localparam logic [4:0] A_CAUSE   = 5'd13;
    localparam logic [4:0] A_EPC     = 5'd14;

    logic [31:0]       badva, count, compare, epc;
    logic [7:0]        status_im;
    logic              status_ie;
    logic              cause_bd, cause_ti;
    logic [1:0]        cause_ip_sw;
    logic [HW_INT-1:0] cause_hw;
    logic [4:0]        cause_exc;
    logic [PW-1:0]     presc;

    logic [7:0]  cause_ip;
    logic [31:0] status_word, cause_word;
    logic        int_req;

    // IP[15] carries the timer, ORed with the top hardware line when that line exists.
    always_comb begin
        cause_ip             = '0;
        cause_ip[1:0]        = cause_ip_sw;
        cause_ip[2 +: HW_INT] = cause_hw;
        cause_ip[7]          = cause_ip[7] | cause_ti;
    end

    assign status_word = {9'd0, 1'b1, 6'd0, status_im, 6'd0, status_exl, status_ie};
    assign cause_word  = {cause_bd, cause_ti, 14'd0, cause_ip, 1'b0, cause_exc, 2'b00};
    assign int_req     = status_ie & ~status_exl & |(cause_ip & status_im);
    assign timer_int   = cause_ti;

    logic [LW-1:0] win;
    logic          found, win_eret, take_int, do_trap, do_eret;
    logic [31:0]   w_pc, w_badva;
    logic          w_bd;
    logic [4:0]    w_code;

    always_comb begin
        found    = 1'b0;
        win      = '0;
        win_eret = 1'b0;
        w_pc     = exc_pc[31:0];
        w_badva  = exc_badva[31:0];
        w_bd     = exc_bd[0];
        w_code   = exc_code[4:0];
        for (int unsigned i = 0; i < LANES; i++) begin
            if (!found && lane_valid[i] && (exc_valid[i] || eret[i])) begin
                found    = 1'b1;
                win      = LW'(i);
                win_eret = ~exc_valid[i];
                w_pc     = exc_pc[32*i +: 32];
                w_badva  = exc_badva[32*i +: 32];
                w_bd     = exc_bd[i];
                w_code   = exc_code[5*i +: 5];
            end
        end
        take_int = reset & int_req & lane_valid[0];
        if (take_int) begin
            win      = '0;
            win_eret = 1'b0;
            w_pc     = exc_pc[31:0];
            w_badva  = exc_badva[31:0];
            w_bd     = exc_bd[0];
            w_code   = exc_code[4:0];
        end
        do_trap     = reset & (take_int | (found & ~win_eret));
        do_eret     = reset & ~take_int & found & win_eret;
        flush       = do_trap | do_eret;
        redirect_pc = do_eret ? epc : EXC_VEC;
        kill_mask   = '0;
        for (int unsigned i = 0; i < LANES; i++)
            kill_mask[i] = flush & (32'(win) <= i);
    end

    logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;
    logic [31:0] count_wv, compare_wv, epc_wv;
    logic [7:0]  status_im_wv;
    logic        status_exl_wv, status_ie_wv;
    logic [1:0]  cause_ip_wv;

    // Ascending lane order lets the youngest surviving write to a register win.
    always_comb begin
        wr_count      = 1'b0;
        wr_compare    = 1'b0;
        wr_status     = 1'b0;
        wr_cause      = 1'b0;
        wr_epc        = 1'b0;
        count_wv      = '0;
        compare_wv    = '0;
        epc_wv        = '0;
        status_im_wv  = '0;
        status_exl_wv = 1'b0;
        status_ie_wv  = 1'b0;
        cause_ip_wv   = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (wr_en[i] && lane_valid[i] && !kill_mask[i]) begin
                case (wr_addr[5*i +: 5])
                    A_COUNT:   begin wr_count = 1'b1;   count_wv = wr_data[32*i +: 32]; end
                    A_COMPARE: begin wr_compare = 1'b1; compare_wv = wr_data[32*i +: 32]; end
                    A_EPC:     begin wr_epc = 1'b1;     epc_wv = wr_data[32*i +: 32]; end
                    A_STATUS: begin
                        wr_status     = 1'b1;
                        status_im_wv  = wr_data[32*i+8 +: 8];
                        status_exl_wv = wr_data[32*i+1];
                        status_ie_wv  = wr_data[32*i];
                    end
                    A_CAUSE: begin
                        wr_cause    = 1'b1;
                        cause_ip_wv = wr_data[32*i+8 +: 2];
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            case (rd_addr[5*i +: 5])
                A_BADVA:   rd_data[32*i +: 32] = badva;
                A_COUNT:   rd_data[32*i +: 32] = count;
                A_COMPARE: rd_data[32*i +: 32] = compare;
                A_STATUS:  rd_data[32*i +: 32] = status_word;
                A_CAUSE:   rd_data[32*i +: 32] = cause_word;
                A_EPC:     rd_data[32*i +: 32] = epc;
                default:   rd_data[32*i +: 32] = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            badva       <= '0;
            count       <= '0;
            compare     <= '0;
            epc         <= '0;
            status_im   <= '0;
            status_exl  <= 1'b0;
            status_ie   <= 1'b0;
            cause_bd    <= 1'b0;
            cause_ti    <= 1'b0;
            cause_ip_sw <= '0;
            cause_hw    <= '0;
            cause_exc   <= '0;
            presc       <= '0;
        end else begin
            cause_hw <= hw_int;

            if (wr_count) begin
                count <= count_wv;
                presc <= '0;
            end else if (presc == PRESC_LAST) begin
                count <= count + 32'd1;
                presc <= '0;
            end else begin
                presc <= presc + PW'(1);
            end

            if (wr_compare) begin
                compare  <= compare_wv;
                cause_ti <= 1'b0;
            end else if (compare != '0 && count == compare) begin
                cause_ti <= 1'b1;
            end

            if (wr_epc)   epc <= epc_wv;
            if (wr_cause) cause_ip_sw <= cause_ip_wv;
            if (wr_status) begin
                status_im  <= status_im_wv;
                status_exl <= status_exl_wv;
                status_ie  <= status_ie_wv;
            end

            // Trap/ERET assignments come last so they override same-cycle MTC0 writes.
            if (do_trap) begin
                if (!status_exl) begin
                    epc      <= w_bd ? (w_pc - 32'd4) : w_pc;
                    cause_bd <= w_bd;
                end
                status_exl <= 1'b1;
                cause_exc  <= take_int ? 5'd0 : w_code;
                if (!take_int && (w_code == 5'd4 || w_code == 5'd5))
                    badva <= w_badva;
            end else if (do_eret) begin
                status_exl <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cp0_multi_issue.sv
// Randomised and directed stimulus for cp0_multi_issue, checked each cycle against a
// behavioural CP0 model through an expectation queue.
module tb_cp0_multi_issue;

    localparam int unsigned L   = 2;
    localparam int unsigned DIV = 2;
    localparam logic [31:0] VEC = 32'hBFC0_0380;

    logic            clk, reset;
    logic [5:0]      hw_int;
    logic [L-1:0]    lane_valid, exc_valid, exc_bd, eret, wr_en;
    logic [5*L-1:0]  exc_code, wr_addr, rd_addr;
    logic [32*L-1:0] exc_pc, exc_badva, wr_data, rd_data;
    logic            flush, status_exl, timer_int;
    logic [L-1:0]    kill_mask;
    logic [31:0]     redirect_pc;

    cp0_multi_issue #(.LANES(L), .HW_INT(6), .COUNT_DIV(DIV), .EXC_VEC(VEC)) dut (
        .clk(clk), .reset(reset), .hw_int(hw_int), .lane_valid(lane_valid),
        .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd),
        .exc_badva(exc_badva), .eret(eret), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data), .flush(flush),
        .kill_mask(kill_mask), .redirect_pc(redirect_pc), .status_exl(status_exl),
        .timer_int(timer_int)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            flush;
        logic [L-1:0]    kill;
        logic [31:0]     redir;
        logic            exl;
        logic            ti;
        logic [32*L-1:0] rd;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   rot = 0;

    // Reference model state
    logic [31:0] m_badva, m_count, m_compare, m_epc;
    logic [7:0]  m_im;
    logic        m_exl, m_ie, m_bd, m_ti;
    logic [1:0]  m_ipsw;
    logic [5:0]  m_hw;
    logic [4:0]  m_exc;
    int          m_ticks;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [7:0] m_ip();
        return {m_ti | m_hw[5], m_hw[4:0], m_ipsw};
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:  return m_badva;
            5'd9:  return m_count;
            5'd11: return m_compare;
            5'd12: return 32'h0040_0000 | (32'(m_im) << 8) | (m_exl ? 32'd2 : 32'd0) | (m_ie ? 32'd1 : 32'd0);
            5'd13: return (32'(m_bd) << 31) | (32'(m_ti) << 30) | (32'(m_ip()) << 8) | (32'(m_exc) << 2);
            5'd14: return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_reset();
        m_badva = 0; m_count = 0; m_compare = 0; m_epc = 0; m_im = 0;
        m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0; m_ipsw = 0; m_hw = 0; m_exc = 0; m_ticks = 0;
    endtask

    // Predict this cycle's outputs, queue them, advance the model, then wait one clock.
    task automatic step();
        exp_t        e;
        bit          have, is_int, is_eret, cnt_wr, cmp_wr, old_exl;
        int          w;
        logic [31:0] old_count, old_compare, d, pc;
        logic [4:0]  code;
        have = 0; is_int = 0; is_eret = 0; w = 0;
        if (reset) begin
            if (m_ie && !m_exl && (m_ip() & m_im) != 0 && lane_valid[0]) begin
                have = 1; is_int = 1;
            end else begin
                for (int i = 0; i < L; i++)
                    if (lane_valid[i] && (exc_valid[i] || eret[i])) begin
                        have = 1; w = i; is_eret = !exc_valid[i];
                        break;
                    end
            end
        end
        e.flush = have;
        e.kill  = '0;
        for (int i = 0; i < L; i++) if (have && i >= w) e.kill[i] = 1'b1;
        e.redir = (have && is_eret) ? m_epc : VEC;
        e.exl   = m_exl;
        e.ti    = m_ti;
        for (int i = 0; i < L; i++) e.rd[i*32 +: 32] = m_read(rd_addr[i*5 +: 5]);
        sb.push_back(e);

        if (!reset) begin
            m_reset();
        end else begin
            old_count = m_count; old_compare = m_compare; old_exl = m_exl;
            cnt_wr = 0; cmp_wr = 0;
            for (int i = 0; i < L; i++) begin
                if (wr_en[i] && lane_valid[i] && !(have && i >= w)) begin
                    d = wr_data[i*32 +: 32];
                    case (wr_addr[i*5 +: 5])
                        5'd9:  begin m_count = d; cnt_wr = 1; end
                        5'd11: begin m_compare = d; cmp_wr = 1; end
                        5'd12: begin m_im = d[15:8]; m_exl = d[1]; m_ie = d[0]; end
                        5'd13: m_ipsw = d[9:8];
                        5'd14: m_epc = d;
                        default: ;
                    endcase
                end
            end
            if (cnt_wr) m_ticks = 0;
            else begin
                m_ticks++;
                if (m_ticks == DIV) begin m_ticks = 0; m_count = m_count + 32'd1; end
            end
            if (cmp_wr) m_ti = 0;
            else if (old_compare != 0 && old_count == old_compare) m_ti = 1;
            m_hw = hw_int;
            if (have && !is_eret) begin
                pc   = exc_pc[w*32 +: 32];
                code = exc_code[w*5 +: 5];
                if (!old_exl) begin
                    m_epc = exc_bd[w] ? pc - 32'd4 : pc;
                    m_bd  = exc_bd[w];
                end
                m_exl = 1;
                m_exc = is_int ? 5'd0 : code;
                if (!is_int && (code == 5'd4 || code == 5'd5)) m_badva = exc_badva[w*32 +: 32];
            end else if (have && is_eret) begin
                m_exl = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("flush", 64'(flush), 64'(e.flush));
            chk("kill_mask", 64'(kill_mask), 64'(e.kill));
            chk("redirect_pc", 64'(redirect_pc), 64'(e.redir));
            chk("status_exl", 64'(status_exl), 64'(e.exl));
            chk("timer_int", 64'(timer_int), 64'(e.ti));
            chk("rd_data_lane0", 64'(rd_data[31:0]), 64'(e.rd[31:0]));
            chk("rd_data_lane1", 64'(rd_data[63:32]), 64'(e.rd[63:32]));
        end
    end

    task automatic idle();
        lane_valid = '0; exc_valid = '0; exc_bd = '0; eret = '0; wr_en = '0;
        exc_code = '0; wr_addr = '0; exc_pc = '0; exc_badva = '0; wr_data = '0;
        hw_int = '0; reset = 1'b1;
        rot++;
        rd_addr[4:0] = (rot % 3 == 0) ? 5'd8 : ((rot % 3 == 1) ? 5'd12 : 5'd9);
        rd_addr[9:5] = rot[0] ? 5'd13 : 5'd14;
    endtask

    task automatic wr(input int ln, input logic [4:0] a, input logic [31:0] d);
        lane_valid[ln] = 1'b1; wr_en[ln] = 1'b1;
        wr_addr[ln*5 +: 5] = a; wr_data[ln*32 +: 32] = d;
    endtask

    task automatic exc(input int ln, input logic [4:0] c, input logic [31:0] pc, input logic bd);
        lane_valid[ln] = 1'b1; exc_valid[ln] = 1'b1;
        exc_code[ln*5 +: 5] = c; exc_pc[ln*32 +: 32] = pc; exc_bd[ln] = bd;
        exc_badva[ln*32 +: 32] = pc ^ 32'h0000_0003;
    endtask

    task automatic idle_n(input int n);
        for (int k = 0; k < n; k++) begin idle(); step(); end
    endtask

    task automatic rand_cycle();
        logic [4:0] alist [7];
        logic [4:0] a;
        alist = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3};
        idle();
        for (int i = 0; i < L; i++) begin
            lane_valid[i]         = ($urandom_range(0, 9) != 0);
            exc_valid[i]          = ($urandom_range(0, 15) == 0);
            eret[i]               = ($urandom_range(0, 19) == 0);
            exc_code[i*5 +: 5]    = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(4, 5)) : 5'($urandom);
            exc_pc[i*32 +: 32]    = $urandom & 32'hFFFF_FFFC;
            exc_bd[i]             = 1'($urandom_range(0, 1));
            exc_badva[i*32 +: 32] = $urandom;
            wr_en[i]              = ($urandom_range(0, 3) == 0);
            a                     = alist[$urandom_range(0, 6)];
            wr_addr[i*5 +: 5]     = a;
            wr_data[i*32 +: 32]   = (a == 5'd11) ? m_count + 32'($urandom_range(1, 30)) :
                                    (a == 5'd9 && $urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom;
            rd_addr[i*5 +: 5]     = alist[$urandom_range(0, 6)];
        end
        hw_int = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'd0;
        reset  = ($urandom_range(0, 199) != 0);
        step();
    endtask

    initial begin
        idle();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m_reset();
        idle_n(2);

        // Single exception on lane 1
        idle(); exc(1, 5'd12, 32'h8000_0104, 1'b0); lane_valid[0] = 1'b1; step();
        idle_n(3);

        // Both lanes except, lane 0 in a delay slot; clear EXL first
        idle(); wr(0, 5'd12, 32'h0); step();
        idle(); exc(0, 5'd8, 32'h8000_0200, 1'b1); exc(1, 5'd12, 32'h8000_0204, 1'b0); step();
        idle_n(3);

        // Timer interrupt through IM[7]
        idle(); wr(0, 5'd12, 32'h0000_8001); step();
        idle(); wr(0, 5'd9, 32'd0); wr(1, 5'd11, 32'd10); step();
        for (int k = 0; k < 26; k++) begin idle(); lane_valid[0] = 1'b1; step(); end
        idle(); wr(0, 5'd11, 32'd0); step();
        idle_n(3);

        // Same-cycle Status writes, then the same writes behind an exception
        idle(); wr(0, 5'd12, 32'h1); wr(1, 5'd12, 32'h0); step();
        idle_n(2);
        idle(); wr(0, 5'd12, 32'h1); wr(1, 5'd12, 32'h0); exc(0, 5'd10, 32'h8000_0300, 1'b0); step();
        idle_n(2);

        // ERET from lane 1, then an exception while EXL is held
        idle(); wr(0, 5'd12, 32'h2); wr(1, 5'd14, 32'h8000_0040); step();
        idle(); lane_valid[0] = 1'b1; lane_valid[1] = 1'b1; eret[1] = 1'b1; step();
        idle(); wr(0, 5'd12, 32'h2); step();
        idle(); exc(0, 5'd4, 32'h8000_0501, 1'b0); step();
        idle_n(2);

        // Reset while TI and EXL are both set
        idle(); wr(0, 5'd9, 32'd0); wr(1, 5'd11, 32'd3); step();
        idle(); wr(0, 5'd12, 32'h2); step();
        idle_n(8);
        idle(); exc(0, 5'd12, 32'h8000_0600, 1'b0); reset = 1'b0; step();
        idle_n(3);

        // Count wrap at 32'hFFFF_FFFF
        idle(); wr(1, 5'd9, 32'hFFFF_FFFE); step();
        idle_n(6);

        for (int k = 0; k < 2500; k++) rand_cycle();
        idle_n(2);

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
